cmm_row_serializer: RTL and testbench
=====================================

Name: cmm_row_serializer

Overview:
- Sink for the row-result interface of the consecutive matrix multiplier (DONE_ROW / ROW_NUM / OUT / DONE).
- Captures each completed 256-bit result row into a 2-entry row buffer.
- Streams the buffered rows out as 32-bit elements over a valid/ready handshake, element 0 first, to a downstream writer (UART or DMA).
- Raises ALL_DONE once the multiplier reports DONE and every captured row has drained.

Parameters:
- ELEM_W, 32: width of one matrix element.
- ELEMS, 8: elements per row; OUT width = ELEM_W*ELEMS.
- ROW_W, 5: width of ROW_NUM.
- DEPTH, 2: row buffer entries; must be a power of 2.

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- RSTN  in  1  asynchronous active-low reset.
- START  in  1  single-cycle pulse; clears the block for a new run (same pulse the multiplier gets).
- DONE_ROW  in  1  row-complete strobe from the multiplier; may be high for 1 or more cycles.
- ROW_NUM  in  ROW_W  index of the completed row; valid while DONE_ROW is high.
- OUT  in  ELEM_W*ELEMS  row data; element i = OUT[ELEM_W*i +: ELEM_W]; valid while DONE_ROW is high.
- DONE  in  1  multiplier run complete; level or pulse.
- M_VALID  out  1  output element valid.
- M_READY  in  1  downstream accepts the element.
- M_DATA  out  ELEM_W  element value.
- M_ROW  out  ROW_W  row index of M_DATA.
- M_ELEM  out  3  element index within the row, 0..ELEMS-1.
- M_LAST  out  1  high on the last element of a row.
- OVERFLOW  out  1  sticky; a row arrived while the buffer was full and was dropped.
- ALL_DONE  out  1  run finished and fully drained.

Behaviour:
- Reset (RSTN=0, async): buffer storage, write/read pointers, count, element counter, edge-detect flops, OVERFLOW, done_seen all go to 0. Result: M_VALID=0, M_DATA=0, M_ROW=0, M_ELEM=0, M_LAST=0, ALL_DONE=0.
- Edge detect: dr_q <= DONE_ROW and dn_q <= DONE every cycle.
  - row_rise = DONE_ROW & ~dr_q.
  - done_rise = DONE & ~dn_q.
  - A multi-cycle DONE_ROW captures exactly once.
- Capture: on a clock edge with row_rise=1 and the buffer not full, store {ROW_NUM, OUT} at wptr; wptr++ (wraps mod DEPTH).
  - Capture-to-output latency is 1 cycle: M_VALID is high in the cycle after the capturing edge.
- Full drop: row_rise while count==DEPTH and no pop in the same cycle → row is discarded and OVERFLOW <= 1. OVERFLOW is cleared only by reset or START.
- Simultaneous capture and pop with count==DEPTH: the capture is accepted and count stays DEPTH.
- Output stream (combinational from registers):
  - M_VALID = (count != 0).
  - M_DATA = head.data[ELEM_W*elem +: ELEM_W].
  - M_ROW = head.row.
  - M_ELEM = elem.
  - M_LAST = M_VALID & (elem == ELEMS-1).
  - When M_VALID=0, M_DATA, M_ROW, M_ELEM and M_LAST are 0.
- Transfer: occurs when M_VALID & M_READY.
  - On a transfer, elem++.
  - If M_LAST, elem <= 0, rptr++ and count-- (pop).
  - While M_VALID=1 and M_READY=0, all M_* outputs hold stable.
- Throughput: one element per cycle at M_READY=1; 8 cycles per row.
- State machine: IDLE / RUN / DRAIN / FIN.
  - IDLE→RUN on START.
  - RUN→DRAIN on done_rise; done_seen <= 1.
  - DRAIN→FIN when count==0 and no row_rise in that cycle.
  - FIN: ALL_DONE=1 as a level; stays in FIN until START.
  - START in any state → RUN.
  - DONE and the final DONE_ROW in the same cycle: the row is captured first, and ALL_DONE waits until it has drained.
- START mid-operation (synchronous clear): flushes the buffer (pointers and count to 0), elem <= 0, clears OVERFLOW, done_seen and ALL_DONE.
  - M_VALID is 0 in the cycle after START.
  - A row_rise in the same cycle as START is captured into the freshly cleared buffer.
- Rows are captured even in IDLE, which tolerates DONE_ROW preceding the first START.

Decomposition:
- Package cmm_pkg:
  - Constants: CMM_ELEM_W=32, CMM_ELEMS=8, CMM_ROW_W=5.
  - Typedef row_entry_t = struct {row[ROW_W], data[ELEM_W*ELEMS]}.
  - State enum cmm_ser_state_e.
- One sub-module, cmm_row_fifo: DEPTH-entry row_entry_t FIFO with push, pop, flush, full, empty and head outputs.
- Edge detect, element counter and FSM stay in the top level.

Test Plan:
- Single row: after reset and START, drive DONE_ROW for 1 cycle with ROW_NUM=3 and OUT elements i = 0x1000_0000+i, M_READY=1.
  → M_VALID rises 1 cycle after capture; 8 beats 0x10000000..0x10000007 with M_ROW=3 and M_ELEM=0..7; M_LAST only on beat 7.
- Backpressure: same row, M_READY toggled 1/0 every cycle.
  → M_* hold stable while stalled; 8 beats in order over 16 cycles; no duplicated or lost beat.
- Overflow: M_READY=0; send rows 0, 1, 2 with 2 cycles between each.
  → rows 0 and 1 buffered; OVERFLOW=1 after row 2.
  → then M_READY=1: 16 beats with M_ROW 0 then 1; OVERFLOW stays 1 until START.
- Full with simultaneous pop: buffer full, and a row_rise coincides with the M_LAST transfer of the head row.
  → new row accepted; OVERFLOW stays 0.
- Completion: DONE and DONE_ROW (row 31) asserted in the same cycle, with DONE held 3 cycles.
  → ALL_DONE=0 until the row 31 M_LAST transfer completes, then 1 the cycle after; it stays 1.
- Mid-run START and reset: START while 5 elements are pending → M_VALID=0 next cycle, and OVERFLOW and ALL_DONE cleared. RSTN low mid-beat → all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/cmm_pkg.sv
// Shared types for the consecutive matrix multiplier row sink.
// Row entry layout and serializer state encoding.
package cmm_pkg;

  localparam int CMM_ELEM_W = 32;
  localparam int CMM_ELEMS  = 8;
  localparam int CMM_ROW_W  = 5;

  typedef struct packed {
    logic [CMM_ROW_W-1:0]            row;
    logic [CMM_ELEM_W*CMM_ELEMS-1:0] data;
  } row_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } cmm_ser_state_e;

endpackage

// File: rtl/cmm_row_fifo.sv
// Small row buffer for the serializer.
// Flush wins over pop; a push alongside flush lands in entry 0.
module cmm_row_fifo
  import cmm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  row_entry_t din,
  output logic       full,
  output logic       empty,
  output row_entry_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  row_entry_t        mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr <= '0;
      if (push) begin
        mem[0] <= din;
        wptr   <= PW'(1);
        count  <= CW'(1);
      end else begin
        wptr  <= '0;
        count <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cmm_row_serializer.sv
// Captures multiplier result rows and streams them as elements.
// Tracks run completion and reports drops on a full buffer.
module cmm_row_serializer
  import cmm_pkg::*;
#(
  parameter int ELEM_W = CMM_ELEM_W,
  parameter int ELEMS  = CMM_ELEMS,
  parameter int ROW_W  = CMM_ROW_W,
  parameter int DEPTH  = 2
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    START,
  input  logic                    DONE_ROW,
  input  logic [ROW_W-1:0]        ROW_NUM,
  input  logic [ELEM_W*ELEMS-1:0] OUT,
  input  logic                    DONE,
  output logic                    M_VALID,
  input  logic                    M_READY,
  output logic [ELEM_W-1:0]       M_DATA,
  output logic [ROW_W-1:0]        M_ROW,
  output logic [2:0]              M_ELEM,
  output logic                    M_LAST,
  output logic                    OVERFLOW,
  output logic                    ALL_DONE
);

  cmm_ser_state_e state_q, state_d;
  logic       done_seen_q, done_seen_d;
  logic       dr_q, dn_q;
  logic       row_rise, done_rise;
  logic       full, empty;
  logic       push, pop, xfer, last;
  logic [2:0] elem;
  logic       ovf_q;
  row_entry_t head, din;

  assign row_rise  = DONE_ROW & ~dr_q;
  assign done_rise = DONE & ~dn_q;

  assign last = (elem == 3'(ELEMS-1));
  assign xfer = M_VALID & M_READY;
  assign pop  = xfer & last & ~START;
  assign push = row_rise & (~full | pop | START);

  assign din.row  = ROW_NUM;
  assign din.data = OUT;

  cmm_row_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (CLK),
    .rst_n(RSTN),
    .push (push),
    .pop  (pop),
    .flush(START),
    .din  (din),
    .full (full),
    .empty(empty),
    .head (head)
  );

  assign M_VALID  = ~empty;
  assign M_DATA   = M_VALID ? head.data[ELEM_W*int'(elem) +: ELEM_W] : '0;
  assign M_ROW    = M_VALID ? head.row : '0;
  assign M_ELEM   = M_VALID ? elem : '0;
  assign M_LAST   = M_VALID & last;
  assign OVERFLOW = ovf_q;
  assign ALL_DONE = (state_q == S_FIN) & done_seen_q;

  // Edge detect, element counter and sticky overflow.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      dr_q  <= 1'b0;
      dn_q  <= 1'b0;
      elem  <= '0;
      ovf_q <= 1'b0;
    end else begin
      dr_q <= DONE_ROW;
      dn_q <= DONE;
      if (START) begin
        elem  <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (xfer) elem <= last ? 3'd0 : elem + 3'd1;
        if (row_rise & full & ~pop) ovf_q <= 1'b1;
      end
    end
  end

  // Run state register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_seen_q <= done_seen_d;
    end
  end

  // Run progression: start, completion seen, fully drained.
  always_comb begin
    state_d     = state_q;
    done_seen_d = done_seen_q;
    if (START) begin
      state_d     = S_RUN;
      done_seen_d = 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (done_rise) begin
            state_d     = S_DRAIN;
            done_seen_d = 1'b1;
          end
        end
        S_DRAIN: begin
          if (empty & ~row_rise) state_d = S_FIN;
        end
        default: state_d = state_q;
      endcase
    end
  end

endmodule

// File: tb/tb_cmm_row_serializer.sv
// Directed bench for the row serializer.
// Hand-computed element streams, overflow, completion and resets.
module tb_cmm_row_serializer;

  logic         CLK = 1'b0;
  logic         RSTN;
  logic         START;
  logic         DONE_ROW;
  logic [4:0]   ROW_NUM;
  logic [255:0] OUT;
  logic         DONE;
  logic         M_VALID;
  logic         M_READY;
  logic [31:0]  M_DATA;
  logic [4:0]   M_ROW;
  logic [2:0]   M_ELEM;
  logic         M_LAST;
  logic         OVERFLOW;
  logic         ALL_DONE;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  cmm_row_serializer dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .START   (START),
    .DONE_ROW(DONE_ROW),
    .ROW_NUM (ROW_NUM),
    .OUT     (OUT),
    .DONE    (DONE),
    .M_VALID (M_VALID),
    .M_READY (M_READY),
    .M_DATA  (M_DATA),
    .M_ROW   (M_ROW),
    .M_ELEM  (M_ELEM),
    .M_LAST  (M_LAST),
    .OVERFLOW(OVERFLOW),
    .ALL_DONE(ALL_DONE)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [255:0] mk_row(input logic [31:0] base);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = base + 32'(i);
    return v;
  endfunction

  task automatic send_row(input logic [4:0] r, input logic [31:0] base);
    ROW_NUM  = r;
    OUT      = mk_row(base);
    DONE_ROW = 1'b1;
    tick();
    DONE_ROW = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input logic [4:0] r,
                          input logic [31:0] base, input int i);
    check({tag, ".valid"}, 64'(M_VALID), 64'd1);
    check({tag, ".data"}, 64'(M_DATA), 64'(base + 32'(i)));
    check({tag, ".row"}, 64'(M_ROW), 64'(r));
    check({tag, ".elem"}, 64'(M_ELEM), 64'(i));
    check({tag, ".last"}, 64'(M_LAST), 64'(i == 7));
  endtask

  task automatic chk_zero(input string tag);
    check({tag, ".valid"}, 64'(M_VALID), 64'd0);
    check({tag, ".data"}, 64'(M_DATA), 64'd0);
    check({tag, ".row"}, 64'(M_ROW), 64'd0);
    check({tag, ".elem"}, 64'(M_ELEM), 64'd0);
    check({tag, ".last"}, 64'(M_LAST), 64'd0);
    check({tag, ".ovf"}, 64'(OVERFLOW), 64'd0);
    check({tag, ".alldone"}, 64'(ALL_DONE), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int exp_i;
    logic rdy;
    RSTN = 1'b0; START = 1'b0; DONE_ROW = 1'b0; ROW_NUM = '0;
    OUT = '0; DONE = 1'b0; M_READY = 1'b0;
    #12;
    chk_zero("reset");
    RSTN = 1'b1;
    tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    check("idle.valid", 64'(M_VALID), 64'd0);

    // single row at full rate
    M_READY = 1'b1;
    send_row(5'd3, 32'h1000_0000);
    for (int i = 0; i < 8; i++) begin
      chk_beat("single", 5'd3, 32'h1000_0000, i);
      tick();
    end
    check("single.empty", 64'(M_VALID), 64'd0);

    // backpressure, ready toggling
    M_READY = 1'b0;
    send_row(5'd3, 32'h1000_0000);
    exp_i = 0;
    for (int c = 0; c < 16; c++) begin
      chk_beat("bp", 5'd3, 32'h1000_0000, exp_i);
      rdy = (c % 2 == 1);
      M_READY = rdy;
      tick();
      if (rdy) exp_i++;
    end
    check("bp.count", 64'(exp_i), 64'd8);
    check("bp.empty", 64'(M_VALID), 64'd0);

    // overflow: third row dropped
    M_READY = 1'b0;
    send_row(5'd0, 32'h2000_0000);
    tick(); tick();
    send_row(5'd1, 32'h2100_0000);
    check("ovf.before", 64'(OVERFLOW), 64'd0);
    tick(); tick();
    send_row(5'd2, 32'h2200_0000);
    check("ovf.set", 64'(OVERFLOW), 64'd1);
    M_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_beat("ovf.r0", 5'd0, 32'h2000_0000, i);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      chk_beat("ovf.r1", 5'd1, 32'h2100_0000, i);
      tick();
    end
    check("ovf.drained", 64'(M_VALID), 64'd0);
    check("ovf.sticky", 64'(OVERFLOW), 64'd1);
    START = 1'b1;
    tick();
    START = 1'b0;
    check("ovf.cleared", 64'(OVERFLOW), 64'd0);

    // full buffer with push on the head's last pop
    M_READY = 1'b0;
    send_row(5'd4, 32'h4000_0000);
    tick();
    send_row(5'd5, 32'h5000_0000);
    tick();
    M_READY = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk_beat("fp.r4", 5'd4, 32'h4000_0000, i);
      tick();
    end
    chk_beat("fp.r4", 5'd4, 32'h4000_0000, 7);
    send_row(5'd6, 32'h6000_0000);
    check("fp.noovf", 64'(OVERFLOW), 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk_beat("fp.r5", 5'd5, 32'h5000_0000, i);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      chk_beat("fp.r6", 5'd6, 32'h6000_0000, i);
      tick();
    end
    check("fp.empty", 64'(M_VALID), 64'd0);

    // completion: DONE with the final row, DONE held 3 cycles
    START = 1'b1;
    tick();
    START = 1'b0;
    DONE = 1'b1;
    send_row(5'd31, 32'hF000_0000);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) DONE = 1'b0;
      chk_beat("fin", 5'd31, 32'hF000_0000, i);
      check("fin.alldone0", 64'(ALL_DONE), 64'd0);
      tick();
    end
    check("fin.empty", 64'(M_VALID), 64'd0);
    check("fin.notyet", 64'(ALL_DONE), 64'd0);
    tick();
    check("fin.alldone", 64'(ALL_DONE), 64'd1);
    tick(); tick();
    check("fin.holds", 64'(ALL_DONE), 64'd1);

    // mid-run START with 5 elements pending
    M_READY = 1'b0;
    send_row(5'd7, 32'h7000_0000);
    tick();
    send_row(5'd8, 32'h8000_0000);
    tick();
    send_row(5'd9, 32'h9000_0000);
    M_READY = 1'b1;
    tick(); tick(); tick();
    M_READY = 1'b0;
    chk_beat("mid", 5'd7, 32'h7000_0000, 3);
    check("mid.ovf", 64'(OVERFLOW), 64'd1);
    check("mid.alldone", 64'(ALL_DONE), 64'd1);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk_zero("mid.start");

    // START coinciding with a row rise keeps that row
    START = 1'b1;
    send_row(5'd12, 32'hC000_0000);
    START = 1'b0;
    chk_beat("st.row", 5'd12, 32'hC000_0000, 0);

    // async reset mid-beat
    M_READY = 1'b1;
    tick(); tick();
    chk_beat("rst.pre", 5'd12, 32'hC000_0000, 2);
    #2;
    RSTN = 1'b0;
    #1;
    chk_zero("rst.async");
    RSTN = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
